serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial, multi-cycle subtractor computing `a - b` LSB-first, one bit per clock, using a registered borrow chain. It is the subtracting counterpart of the team's adder blocks. It is a small arithmetic datapath unit with a start/done handshake for use by a sequencing FSM or a testbench driver. It trades WIDTH cycles of latency for a single-bit datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 1 or more.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start`  input  1  request a subtraction; honoured only when idle.
- `a`  input  WIDTH  minuend; sampled only on the accepting edge.
- `b`  input  WIDTH  subtrahend; sampled only on the accepting edge.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse; `diff` and `borrow` are valid and newly updated.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`; held until the next completion.
- `borrow`  output  1  final borrow out: 1 iff `a < b` (unsigned); held with `diff`.

## Operation
- **Internal state**
  - State register with three states: IDLE, SHIFT, DONE.
  - Operand shift registers `sa` and `sb`, each WIDTH bits.
  - Result shift register `sr`, WIDTH bits.
  - Borrow flop `br`.
  - Bit counter `cnt`, sized to hold 0..WIDTH-1.
- **IDLE**
  - If `start` = 1: `sa`←`a`, `sb`←`b`, `br`←0, `cnt`←0, `sr`←0, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**, on each edge, with `x = sa[0]`, `y = sb[0]`:
  - Difference bit `d = x ^ y ^ br`.
  - Next borrow `br_n = (~x & y) | (~(x ^ y) & br)`.
  - `sr` ← `{d, sr[WIDTH-1:1]}`.
  - `sa` and `sb` shift right by one; the shift-in value is a don't-care.
  - `br` ← `br_n`.
  - If `cnt` = WIDTH-1: load `diff` ← `{d, sr[WIDTH-1:1]}` and `borrow` ← `br_n`, then go to DONE.
  - Otherwise `cnt` ← `cnt + 1`.
- **DONE**
  - Unconditionally return to IDLE on the next edge.
  - `start` is ignored in this state.
- **Outputs**
  - `busy` = 1 only in SHIFT.
  - `done` = 1 only in DONE.
  - `diff` and `borrow` are registers. They change only on the SHIFT→DONE edge and on reset.
- **`start` outside IDLE**: ignored, with no effect on in-flight data. `a` and `b` may change freely after the accepting edge.
- **WIDTH = 1**: `cnt` is a single bit that stays at 0. The block degenerates to a registered half subtractor: `diff = a ^ b`, `borrow = ~a & b`.

## Timing
- **Reset values**: state = IDLE, `busy` = 0, `done` = 0, `diff` = 0, `borrow` = 0. Internal registers are also cleared.
- **Reset priority**: `rst` has priority over every other input on the same edge.
- **Reset mid-operation** (SHIFT or DONE): aborts the operation. The next cycle shows reset values and no `done` pulse.
- **Cycle-level sequence**, with E0 the edge where `start` is accepted in IDLE:
  - `busy` = 1 in the cycles following edges E0 .. E(WIDTH-1).
  - The last bit is processed at edge E(WIDTH).
  - `done` = 1 and new `diff`/`borrow` are valid in the cycle after E(WIDTH).
  - The state is back in IDLE after E(WIDTH+1).
- **Latency**: WIDTH cycles from the accepting edge to `done`.
- **Throughput**: one result per WIDTH+2 cycles. `start` held high continuously is accepted at E0, E(WIDTH+2), E(2·WIDTH+4), and so on.
- `busy` and `done` are never high together.

## Test plan
- **Basic, no borrow**: WIDTH=8, reset, then `a`=0x5A, `b`=0x3C, `start` pulsed for 1 cycle. Required: `busy` high for 8 cycles; `done` pulses exactly 8 cycles after the accepting edge with `diff`=0x1E, `borrow`=0.
- **Underflow and equality**: `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow`=1. `a`=0x10, `b`=0x20 → `diff`=0xF0, `borrow`=1. `a`=0xFF, `b`=0xFF → `diff`=0x00, `borrow`=0.
- **Ignored start and held result**: while busy on 0x5A−0x3C, pulse `start` with `a`=0x00, `b`=0xFF. Required: result is still 0x1E/0 and only one `done` pulse occurs. `diff` holds 0x1E through the following idle cycles.
- **Reset mid-op**: assert `rst` for 1 cycle at the 4th SHIFT cycle. Required: next cycle `busy`=0, `done`=0, `diff`=0, `borrow`=0, and no `done` pulse follows. A fresh 0x80−0x01 then yields 0x7F/0.
- **Back-to-back**: `start` tied high for three operations. Required: `done` pulses spaced exactly WIDTH+2 = 10 cycles apart.
- **WIDTH=1 exhaustive**: inputs 00, 01, 10, 11 as `a`,`b`. Required `diff`/`borrow` = 0/0, 1/1, 1/0, 0/0, each with `done` one cycle after acceptance.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing (a - b) mod 2^WIDTH, LSB first, one bit per
//   clock, through a registered borrow chain. A start/done handshake lets a
//   sequencing FSM or a driver issue one subtraction every WIDTH+2 cycles.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   start   : request a subtraction, accepted only while idle
//   a, b    : minuend / subtrahend, captured on the accepting edge
//   busy    : high while bits are being processed
//   done    : one-cycle pulse when diff/borrow have just been updated
//   diff    : (a - b) mod 2^WIDTH, held until the next completion
//   borrow  : final borrow out, 1 iff a < b (unsigned), held with diff
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // A one-bit counter is kept for WIDTH = 1; it simply stays at zero.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             d_bit;
  logic             br_n;

  // Full-subtractor difference bit.
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Full-subtractor borrow out: borrow when y exceeds x, or when they are
  // equal and a borrow is already pending.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // Shift right by one with a new MSB; written without part-selects so it
  // stays legal for WIDTH = 1.
  function automatic logic [WIDTH-1:0] shift_in_msb(input logic [WIDTH-1:0] v,
                                                    input logic msb);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = msb;
    return r;
  endfunction

  assign d_bit = sub_diff(sa_q[0], sb_q[0], br_q);
  assign br_n  = sub_borrow(sa_q[0], sb_q[0], br_q);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sr_d = shift_in_msb(sr_q, d_bit);
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        br_d = br_n;
        if (cnt_q == CNT_LAST) begin
          // Publish the completed word, including the bit produced this edge.
          diff_d   = shift_in_msb(sr_q, d_bit);
          borrow_d = br_n;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
